// File: rtl/feature_quant_packer.sv
// Quantizes raw unsigned features to 2-bit codes and packs NUM_FEAT codes per output vector,
// double-buffered. Define FEAT_QUANT_ERR_CNT_EN to add a saturating framing-error counter (err_cnt).
module feature_quant_packer #(
  parameter int NUM_FEAT = 16,
  parameter int IN_W     = 8,
  parameter int Q_W      = 2,
  parameter int THR0     = 64,
  parameter int THR1     = 128,
  parameter int THR2     = 192
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NUM_FEAT*Q_W-1:0]  m_data,
  output logic                     err
`ifdef FEAT_QUANT_ERR_CNT_EN
  ,
  output logic [15:0]              err_cnt
`endif
);

  localparam int VEC_W = NUM_FEAT * Q_W;
  localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_FEAT - 1);
  localparam logic [IN_W-1:0]  THR0_V  = IN_W'(THR0);
  localparam logic [IN_W-1:0]  THR1_V  = IN_W'(THR1);
  localparam logic [IN_W-1:0]  THR2_V  = IN_W'(THR2);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [VEC_W-1:0] asm_q, asm_d;
  logic [VEC_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             err_q, err_d;

  logic [Q_W-1:0]      q_code;
  logic [NUM_FEAT-1:0] fld_sel;
  logic [VEC_W-1:0]    asm_ins;
  logic                accept;
  logic                out_free;

  always_comb begin
    if (s_data >= THR2_V)      q_code = Q_W'(3);
    else if (s_data >= THR1_V) q_code = Q_W'(2);
    else if (s_data >= THR0_V) q_code = Q_W'(1);
    else                       q_code = Q_W'(0);
  end

  // asm_ins is the assembly buffer with the current code dropped into the slot named by count_q;
  // on the final beat it is the complete vector.
  for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_field
    assign fld_sel[gi] = (count_q == CNT_W'(gi));
    assign asm_ins[gi*Q_W +: Q_W] = fld_sel[gi] ? q_code : asm_q[gi*Q_W +: Q_W];
  end

  assign s_ready  = (state_q == ST_FILL);
  assign accept   = s_valid & s_ready;
  assign out_free = ~m_valid_q | m_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    asm_d     = asm_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    err_d     = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (count_q != CNT_MAX) begin
            if (s_last) begin
              count_d = '0;
              asm_d   = '0;
              err_d   = 1'b1;
            end else begin
              asm_d   = asm_ins;
              count_d = count_q + 1'b1;
            end
          end else begin
            // Vector complete: a missing s_last is flagged but the vector is still delivered.
            count_d = '0;
            err_d   = ~s_last;
            if (out_free) begin
              m_data_d  = asm_ins;
              m_valid_d = 1'b1;
              asm_d     = '0;
            end else begin
              asm_d   = asm_ins;
              state_d = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (m_valid_q && m_ready) begin
          m_data_d  = asm_q;
          m_valid_d = 1'b1;
          asm_d     = '0;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      count_q   <= '0;
      asm_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      asm_q     <= asm_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

`ifdef FEAT_QUANT_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_feature_quant_packer.sv
// Scoreboard bench for feature_quant_packer: stimulus pushes expected vectors, a negedge monitor
// pops and compares on every output handshake.
module tb_feature_quant_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        err;
`ifdef FEAT_QUANT_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks  = 0;
  int errors  = 0;
  int err_seen = 0;
  int exp_err  = 0;
  logic [31:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev  = '0;

  always #5 clk = ~clk;

  feature_quant_packer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err     (err)
`ifdef FEAT_QUANT_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted output vector against the scoreboard.
  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (stall_prev && m_valid === 1'b1) chk("m_data_hold", m_data, data_prev);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_m_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("m_data", m_data, e);
        $display("vector out m_data=%h expected=%h", m_data, e);
      end
    end
    stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
    data_prev  = m_data;
  end

  function automatic logic [7:0] val(input int kind, input int i);
    logic [7:0] pat1 [4];
    logic [7:0] bnd  [8];
    pat1 = '{8'd0, 8'd64, 8'd128, 8'd192};
    bnd  = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255, 8'd0};
    case (kind)
      0: return pat1[i % 4];
      1: return bnd[i % 8];
      2: return 8'd255;
      3: return 8'd64;
      4: return (i % 2 == 0) ? 8'd192 : 8'd0;
      default: return 8'd128;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("s_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_pattern(input int kind, input int first, input int nbeats, input int last_at);
    for (int i = first; i < first + nbeats; i++) send(val(kind, i), (i == last_at));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_m_data", m_data, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
`ifdef FEAT_QUANT_ERR_CNT_EN
    chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

    // Basic packing and one-cycle latency
    exp_q.push_back(32'hE4E4E4E4);
    send_pattern(0, 0, 16, 15);
    chk("latency_m_valid", {31'd0, m_valid}, 32'd1);
    chk("basic_err", {31'd0, err}, 32'd0);
    idle(2);

    // Threshold boundaries: codes 0,1,1,2,2,3,3,0
    exp_q.push_back(32'h3E943E94);
    send_pattern(1, 0, 16, 15);
    idle(2);

    // Backpressure: two vectors, the second parks in HOLD
    m_ready = 1'b0;
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h55555555);
    send_pattern(2, 0, 16, 15);
    send_pattern(3, 0, 16, 15);
    chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
    chk("hold_m_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("reload_m_valid", {31'd0, m_valid}, 32'd1);
    chk("reload_s_ready", {31'd0, s_ready}, 32'd1);
    idle(2);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("drained_m_valid", {31'd0, m_valid}, 32'd0);
    chk("queue_after_hold", exp_q.size(), 32'd0);

    // Final accept coincides with m_ready on the pending vector
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'hAAAAAAAA);
    send_pattern(4, 0, 16, 15);
    send_pattern(5, 0, 15, -1);
    m_ready = 1'b1;
    send(8'd128, 1'b1);
    chk("swap_m_valid", {31'd0, m_valid}, 32'd1);
    chk("swap_s_ready", {31'd0, s_ready}, 32'd1);
    idle(2);

    // Early s_last on beat 5, then a clean vector
    send_pattern(0, 0, 6, 5);
    exp_err++;
    idle(3);
    chk("early_last_err", err_seen, exp_err);
    chk("early_last_no_out", {31'd0, m_valid}, 32'd0);
    exp_q.push_back(32'hE4E4E4E4);
    send_pattern(0, 0, 16, 15);
    idle(2);

    // Missing s_last: vector still delivered, err pulses
    exp_q.push_back(32'hAAAAAAAA);
    send_pattern(5, 0, 16, -1);
    exp_err++;
    idle(2);
    chk("missing_last_err", err_seen, exp_err);
`ifdef FEAT_QUANT_ERR_CNT_EN
    chk("err_cnt_count", {16'd0, err_cnt}, exp_err);
    while (exp_err < 65536) begin
      send(8'd0, 1'b1);
      exp_err++;
    end
    idle(3);
    chk("err_cnt_saturate", {16'd0, err_cnt}, 32'h0000FFFF);
    chk("err_pulses_total", err_seen, exp_err);
`endif

    // Reset mid-vector discards the partial vector with no err pulse
    send_pattern(2, 0, 8, -1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_m_data", m_data, 32'd0);
    chk("midrst_no_err", err_seen, exp_err);
    exp_q.push_back(32'h3E943E94);
    send_pattern(1, 0, 16, 15);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      idle(2);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
